// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: load-type codes, FSM encoding,
// bus size codes and the size/replication helpers used on the request side.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  // Decoded load type
  typedef enum logic [2:0] {
    LT_LB  = 3'd0,
    LT_LBU = 3'd1,
    LT_LH  = 3'd2,
    LT_LHU = 3'd3,
    LT_LW  = 3'd4
  } load_type_e;

  // Access FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Bus size codes
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Load size from load type; unknown codes fall back to a word access
  function automatic logic [1:0] load_size(input logic [2:0] lt);
    case (lt)
      LT_LB, LT_LBU: load_size = SZ_BYTE;
      LT_LH, LT_LHU: load_size = SZ_HALF;
      default:       load_size = SZ_WORD;
    endcase
  endfunction

  // Store size from strobe count; an all-zero strobe issues as a byte write
  function automatic logic [1:0] store_size(input logic [3:0] wen);
    int unsigned n;
    n = $countones(wen);
    if (n == 4)      store_size = SZ_WORD;
    else if (n == 2) store_size = SZ_HALF;
    else             store_size = SZ_BYTE;
  endfunction

  // Replicate the low byte/half across the word so any lane sees it
  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] sz,
                                                  input logic [DATA_W-1:0] d);
    case (sz)
      SZ_BYTE: replicate = {4{d[7:0]}};
      SZ_HALF: replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Read-side lane select and sign/zero extension (inverse of store replication).
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]        i_load_type,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_data_rdata,
  output logic [DATA_W-1:0] o_rdata_next
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed lane, then extend according to load type
  always_comb begin
    w_byte       = i_data_rdata[7:0];
    w_half       = i_addr_lo[1] ? i_data_rdata[31:16] : i_data_rdata[15:0];
    o_rdata_next = i_data_rdata;
    case (i_addr_lo)
      2'd0: w_byte = i_data_rdata[7:0];
      2'd1: w_byte = i_data_rdata[15:8];
      2'd2: w_byte = i_data_rdata[23:16];
      2'd3: w_byte = i_data_rdata[31:24];
      default: w_byte = i_data_rdata[7:0];
    endcase
    case (i_load_type)
      LT_LB:   o_rdata_next = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_rdata_next = {24'd0, w_byte};
      LT_LH:   o_rdata_next = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_rdata_next = {16'd0, w_half};
      default: o_rdata_next = i_data_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_sram_if.sv
// MEM-stage load/store unit: one outstanding SRAM-like bus access at a time.
// Optional feature macro: LSU_ALIGN_CHECK_EN enables misalignment exceptions
// (adel/ades) and suppresses the faulting access.
module lsu_sram_if
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_en,
  input  logic              i_mem_wr,
  input  logic [3:0]        i_mem_wen,
  input  logic [2:0]        i_load_type,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_adel,
  output logic              o_ades,
  output logic              o_data_req,
  output logic              o_data_wr,
  output logic [1:0]        o_data_size,
  output logic [ADDR_W-1:0] o_data_addr,
  output logic [DATA_W-1:0] o_data_wdata,
  input  logic              i_data_addr_ok,
  input  logic              i_data_data_ok,
  input  logic [DATA_W-1:0] i_data_rdata
);

  lsu_state_e        r_state;
  logic              r_req;
  logic              r_done;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_lt;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_size;
  logic              w_adel;
  logic              w_ades;
  logic              w_err;
  logic              w_idle;
  logic [DATA_W-1:0] w_rdata_next;

  // Request-side decode and address-error detection (only meaningful in IDLE)
  always_comb begin
    w_idle = (r_state == ST_IDLE);
    w_size = i_mem_wr ? store_size(i_mem_wen) : load_size(i_load_type);
`ifdef LSU_ALIGN_CHECK_EN
    w_adel = w_idle & i_mem_en & ~i_mem_wr &
             (((w_size == SZ_HALF) & i_addr[0]) |
              ((w_size == SZ_WORD) & (i_addr[1:0] != 2'b00)));
    w_ades = w_idle & i_mem_en & i_mem_wr & (i_mem_wen == 4'b0000);
`else
    w_adel = 1'b0;
    w_ades = 1'b0;
`endif
    w_err  = w_adel | w_ades;
  end

  lsu_load_ext u_load_ext (
    .i_load_type  (r_lt),
    .i_addr_lo    (r_addr[1:0]),
    .i_data_rdata (i_data_rdata),
    .o_rdata_next (w_rdata_next)
  );

  // Access FSM with registered bus request, done pulse and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_lt    <= 3'd0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_mem_en && !w_err) begin
            r_state <= ST_ADDR;
            r_req   <= 1'b1;
            r_wr    <= i_mem_wr;
            r_size  <= w_size;
            r_addr  <= i_addr;
            r_wdata <= replicate(w_size, i_wdata);
            r_lt    <= i_load_type;
          end
        end
        ST_ADDR: begin
          if (i_data_addr_ok) begin
            r_req <= 1'b0;
            if (i_data_data_ok) begin
              r_rdata <= w_rdata_next;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (i_data_data_ok) begin
            r_rdata <= w_rdata_next;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pipeline hold: a new accepted access or one still in flight
  always_comb begin
    o_stall = (w_idle & i_mem_en & ~w_err) |
              (r_state == ST_ADDR) | (r_state == ST_DATA);
  end

  assign o_adel       = w_adel;
  assign o_ades       = w_ades;
  assign o_done       = r_done;
  assign o_rdata      = r_rdata;
  assign o_data_req   = r_req;
  assign o_data_wr    = r_wr;
  assign o_data_size  = r_size;
  assign o_data_addr  = r_addr;
  assign o_data_wdata = r_wdata;

endmodule

// File: doc/lsu_sram_if.md
# lsu_sram_if

Load/store access unit that sits in the MEM stage and turns the decoder's memory controls into a single-outstanding SRAM-like data-bus transaction. Stores are driven by the decoded byte strobes; loads are driven by the decoded load type. On the read side the unit selects the byte lane and sign- or zero-extends the data back into a register value, which is the inverse of the store-side lane placement. While an access is in flight it stalls the pipeline, and it reports misaligned-address exceptions before any bus request is issued.

## Interface
- ADDR_W, 32, data-bus address width
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- mem_en  in  1  MEM-stage instruction is a load or store
- mem_wr  in  1  1 = store, 0 = load
- mem_wen  in  4  decoded store byte strobes (1111 SW; 0011/1100 SH; one-hot SB; 0000 = unaligned store)
- load_type  in  3  LB/LBU/LH/LHU/LW code (lsu_pkg)
- addr  in  ADDR_W  effective address
- wdata  in  32  rt value, unshifted
- stall  out  1  hold the pipeline
- done  out  1  one-cycle pulse, access complete
- rdata  out  32  extended load result, valid while done=1
- adel / ades  out  1  load / store address error (combinational, IDLE only)
- data_req, data_wr  out  1  bus request, write flag
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  ADDR_W;  data_wdata  out  32
- data_addr_ok, data_data_ok  in  1;  data_rdata  in  32

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: if mem_en=1 and there is no address error, register mem_wr, size, addr, the replicated wdata and load_type, then go to ADDR. If there is an address error, raise adel/ades, make no request and stay in IDLE.
- ADDR: data_req=1 with registered fields held stable. If data_addr_ok=1 and data_data_ok=1, go to DONE. If only data_addr_ok=1, go to DATA.
- DATA: data_req=0; on data_data_ok=1 capture data_rdata and go to DONE.
- DONE: done=1, stall=0, rdata valid; always go to IDLE. A request is never re-accepted in DONE.
- stall = (IDLE & mem_en & ~err) | ADDR | DATA.
- Size derivation:
  - Store: 4 strobes set → 2; 2 set → 1; 1 set → 0.
  - Load: from load_type.
- Store data replication: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load extension uses addr[1:0]:
  - LB/LBU select byte lane addr[1:0].
  - LH/LHU select half lane addr[1].
  - Sign extension for LB/LH; zero extension for LBU/LHU.
- Error rules:
  - ades = mem_wr & mem_wen==0000.
  - adel = load & ((half & addr[0]) | (word & addr[1:0]!=0)).
- data_ok arriving in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; data_req 0, done 0, rdata 0, registered bus fields 0.
- Minimum access: mem_en seen at cycle T, data_req=1 at T+1, and with addr_ok and data_ok both at T+1, done=1 at T+2. stall is high for T and T+1.
- data_req stays high until data_addr_ok; request fields do not change while it is high.
- Reset in ADDR/DATA returns to IDLE at once. The late response to the abandoned transaction is dropped.
- mem_en deasserting mid-access has no effect; the access completes.

## Configuration
- LSU_ALIGN_CHECK_EN defined: adel/ades computed as above, and erroneous accesses are suppressed.
- Not defined: adel=ades=0. Every mem_en access is issued using its derived size. A store with mem_wen=0000 is issued as a byte write with data_wr=1 and size 0.

## Structure
- lsu_pkg holds:
  - load_type codes: LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LW
  - FSM state encoding
  - size constants: SZ_BYTE, SZ_HALF, SZ_WORD
- Sub-module lsu_load_ext is combinational: load_type, addr[1:0], data_rdata → rdata_next.

## Test plan
- SW at 0x100, wdata 0xDEADBEEF, addr_ok and data_ok both at T+1 → data_wr=1, size 2, data_wdata 0xDEADBEEF; done at T+2; stall only in T and T+1.
- SB at 0x103, wdata 0x000000A5, mem_wen 1000, addr_ok delayed 3 cycles → data_wdata 0xA5A5A5A5, size 0, data_req held 3 cycles with stable fields.
- LB at 0x102, data_rdata 0x1280FF00 → rdata 0xFFFFFF80. Same access as LBU → rdata 0x00000080. LH at 0x102 → 0x00001280.
- LW at 0x101 with macro defined → adel=1, data_req never asserted, stall=0. With macro undefined → request issued with size 2.
- rst asserted in DATA, then data_ok one cycle after rst release → state IDLE, done stays 0, rdata stays 0.
- Back-to-back LW then SW → second data_req rises exactly one cycle after the first done pulse.
